lfsr_encrypt_engine: RTL and testbench

//  Hardware encryptor; the sending end of the LFSR message-cipher protocol.
//  - Takes a plaintext byte stream plus config (tap pattern, seed, pre-length).
//  - Emits a fixed 64-byte ciphertext frame: space pre-pad, body, space post-pad.
//  - Each byte is XORed with the LFSR state; its even-parity bit goes into bit 7.
//  - Sits ahead of data memory, which it fills for the decrypt/depad programs.

---
 rtl/lfsr_cipher_pkg.sv | 33 +++
 rtl/lfsr7_step.sv | 10 +
 rtl/lfsr_encrypt_engine.sv | 142 ++++++++++++++
 tb/tb_lfsr_encrypt_engine.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_cipher_pkg.sv
// Shared constants, tap table, FSM state type and byte helpers for the LFSR message cipher.
package lfsr_cipher_pkg;

    localparam int FRAME_LEN = 64;
    localparam int MAX_MSG   = 49;
    localparam int PRE_MIN   = 10;
    localparam int PRE_MAX   = 15;

    localparam logic [7:0] PAD_CHAR     = 8'h20;
    localparam logic [6:0] SEED_DEFAULT = 7'h01;

    localparam logic [6:0] TAPS [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                        7'h69, 7'h5C, 7'h7E, 7'h7B};

    typedef enum logic [2:0] {IDLE, PRE, BODY, POST, DONE} enc_state_t;

    // Bit 7 of the source character is dropped; bit 7 of the result is even parity of the cipher.
    function automatic logic [7:0] cipher_byte(input logic [7:0] pad, input logic [6:0] lfsr);
        logic [6:0] c;
        c = pad[6:0] ^ lfsr;
        return {^c, c};
    endfunction

    // The 4-bit field cannot exceed PRE_MAX, so only the lower bound needs clamping.
    function automatic logic [3:0] clamp_pre(input logic [3:0] v);
        return (v < 4'(PRE_MIN)) ? 4'(PRE_MIN) : v;
    endfunction

    function automatic logic [5:0] clamp_len(input logic [5:0] v);
        return (v > 6'(MAX_MSG)) ? 6'(MAX_MSG) : v;
    endfunction

endpackage

// File: rtl/lfsr7_step.sv
// One combinational step of the 7-bit Fibonacci LFSR; used by both encrypt and decrypt sides.
module lfsr7_step (
    input  logic [6:0] i_state,
    input  logic [6:0] i_taps,
    output logic [6:0] o_next
);

    assign o_next = {i_state[5:0], ^(i_state & i_taps)};

endmodule

// File: rtl/lfsr_encrypt_engine.sv
// LFSR frame encryptor: 64-byte frame of space pre-pad, plaintext body and space post-pad.
// Optional build macro ERR_INJECT_EN adds inj_mask, XORed into bytes 24..63 after parity.
module lfsr_encrypt_engine
    import lfsr_cipher_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic [6:0] cfg_taps,
    input  logic [6:0] cfg_seed,
    input  logic [3:0] cfg_pre_len,
    input  logic [5:0] cfg_msg_len,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
`ifdef ERR_INJECT_EN
    ,
    input  logic [7:0] inj_mask
`endif
);

    enc_state_t r_state;
    enc_state_t w_state_nxt;
    logic [5:0] r_idx;
    logic [5:0] r_body_cnt;
    logic [6:0] r_lfsr;
    logic [6:0] r_taps;
    logic [3:0] r_pre;
    logic [5:0] r_len;
    logic [7:0] r_out_data;
    logic       r_out_valid;
    logic       r_done;

    logic       w_adv;
    logic       w_start;
    logic       w_in_fire;
    logic       w_load;
    logic [5:0] w_idx;
    logic [6:0] w_idx_nxt;
    logic [5:0] w_body_nxt;
    logic [6:0] w_cur_lfsr;
    logic [6:0] w_cur_taps;
    logic [6:0] w_lfsr_nxt;
    logic [7:0] w_pad;
    logic [7:0] w_byte;
    logic [7:0] w_out_byte;

    assign w_adv     = !r_out_valid || out_ready;
    assign w_start   = (r_state == IDLE) && start && !r_done;
    assign in_ready  = (r_state == BODY) && w_adv;
    assign w_in_fire = in_ready && in_valid;
    assign w_load    = w_start || w_in_fire ||
                       (w_adv && ((r_state == PRE) || (r_state == POST)));

    // Byte 0 is produced straight from the cfg inputs so out_valid rises the cycle after start.
    assign w_idx      = (r_state == IDLE) ? 6'd0 : r_idx;
    assign w_idx_nxt  = {1'b0, w_idx} + 7'd1;
    assign w_body_nxt = r_body_cnt + 6'd1;
    assign w_cur_lfsr = (r_state != IDLE) ? r_lfsr :
                        (cfg_seed == 7'd0) ? SEED_DEFAULT : cfg_seed;
    assign w_cur_taps = (r_state == IDLE) ? cfg_taps : r_taps;

    lfsr7_step u_step (
        .i_state (w_cur_lfsr),
        .i_taps  (w_cur_taps),
        .o_next  (w_lfsr_nxt)
    );

    assign w_pad  = (r_state == BODY) ? in_data : PAD_CHAR;
    assign w_byte = cipher_byte(w_pad, w_cur_lfsr);

`ifdef ERR_INJECT_EN
    assign w_out_byte = (w_idx >= 6'd24) ? (w_byte ^ inj_mask) : w_byte;
`else
    assign w_out_byte = w_byte;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_start) w_state_nxt = PRE;
            PRE: begin
                if (w_adv && (w_idx_nxt == {3'd0, r_pre}))
                    w_state_nxt = (r_len == 6'd0) ? POST : BODY;
            end
            BODY: begin
                if (w_in_fire && (w_body_nxt == r_len))
                    w_state_nxt = (w_idx_nxt == 7'(FRAME_LEN)) ? DONE : POST;
            end
            POST: if (w_adv && (w_idx_nxt == 7'(FRAME_LEN))) w_state_nxt = DONE;
            DONE: if (r_out_valid && out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= IDLE;
            r_idx       <= 6'd0;
            r_body_cnt  <= 6'd0;
            r_out_data  <= 8'd0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == DONE) && r_out_valid && out_ready;
            if (w_load) begin
                r_out_data  <= w_out_byte;
                r_out_valid <= 1'b1;
                r_idx       <= w_idx_nxt[5:0];
            end else if (w_adv) begin
                r_out_valid <= 1'b0;
            end
            if (w_start)
                r_body_cnt <= 6'd0;
            else if (w_in_fire)
                r_body_cnt <= w_body_nxt;
        end
    end

    // Config and LFSR state are only consulted while busy, so they need no reset.
    always_ff @(posedge Clk) begin
        if (w_start) begin
            r_taps <= cfg_taps;
            r_pre  <= clamp_pre(cfg_pre_len);
            r_len  <= clamp_len(cfg_msg_len);
        end
        if (w_load)
            r_lfsr <= w_lfsr_nxt;
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// Randomized bench for lfsr_encrypt_engine against a frame-level reference model.
module tb_lfsr_encrypt_engine;
    import lfsr_cipher_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       start = 1'b0;
    logic [6:0] cfg_taps = '0;
    logic [6:0] cfg_seed = '0;
    logic [3:0] cfg_pre_len = '0;
    logic [5:0] cfg_msg_len = '0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;
`ifdef ERR_INJECT_EN
    logic [7:0] inj_mask = '0;
`endif

    always #5 Clk = ~Clk;

    lfsr_encrypt_engine dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .start       (start),
        .cfg_taps    (cfg_taps),
        .cfg_seed    (cfg_seed),
        .cfg_pre_len (cfg_pre_len),
        .cfg_msg_len (cfg_msg_len),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
`ifdef ERR_INJECT_EN
        ,
        .inj_mask    (inj_mask)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] msg      [64];
    logic [7:0] exp_f    [64];
    logic [7:0] cap      [64];
    logic [7:0] prev_cap [64];

    int   out_cnt = 0, in_cnt = 0, exp_len = 0, exp_pre = 0;
    bit   mon_en = 0, drv_en = 0, done_pend = 0, prev_stall = 0, stall_used = 0;
    int   ready_mode = 0, valid_mode = 0, stall_left = 0, cyc = 0;
    logic [7:0] prev_data = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Frame = spaces, then the first L characters, then spaces; every byte XORed with the
    // running LFSR value and topped with even parity of its low seven bits.
    function automatic void build_model(input logic [6:0] taps, input logic [6:0] seed,
                                        input logic [3:0] pre, input logic [5:0] len,
                                        input logic [7:0] mask);
        int p, l;
        logic [6:0] s;
        logic [7:0] ch;
        logic [6:0] c;
        p = (int'(pre) < 10) ? 10 : int'(pre);
        l = (int'(len) > 49) ? 49 : int'(len);
        s = (seed == 7'd0) ? 7'h01 : seed;
        for (int i = 0; i < 64; i++) begin
            ch = (i >= p && i < p + l) ? msg[i - p] : 8'h20;
            c  = ch[6:0] ^ s;
            exp_f[i] = {1'($countones(c) & 1), c};
            if (i >= 24) exp_f[i] = exp_f[i] ^ mask;
            s = {s[5:0], 1'($countones(s & taps) & 1)};
        end
        exp_pre = p;
        exp_len = l;
    endfunction

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
            if (done_pend) begin
                check("done_pulse", done, 1);
                check("busy_fall", busy, 0);
                done_pend = 0;
            end else begin
                check("done_low", done, 0);
            end
            if (out_valid && out_ready) begin
                if (out_cnt < 64) begin
                    check($sformatf("out_byte%0d", out_cnt), out_data, exp_f[out_cnt]);
                    cap[out_cnt] = out_data;
                end else begin
                    check("out_extra", out_cnt, 63);
                end
                out_cnt++;
                if (out_cnt == 64) done_pend = 1;
            end
            if (in_valid && in_ready) begin
                check("in_within_len", in_cnt < exp_len, 1);
                in_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    always @(posedge Clk) begin
        #1;
        if (drv_en) begin
            in_valid = (valid_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_data  = msg[in_cnt % 64];
            if (ready_mode == 2 && !stall_used && out_cnt == exp_pre + 3) begin
                stall_left = 5;
                stall_used = 1;
            end
            if (stall_left > 0) begin
                out_ready  = 1'b0;
                stall_left = stall_left - 1;
            end else if (ready_mode == 1) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic fill_msg();
        for (int i = 0; i < 64; i++) msg[i] = 8'($urandom_range(8'h20, 8'h9F));
    endtask

    task automatic run_frame(input logic [6:0] taps, input logic [6:0] seed,
                             input logic [3:0] pre, input logic [5:0] len,
                             input int rmode, input int vmode, input logic [7:0] mask,
                             input bit poke_busy, input int abort_at);
        int s_cyc, t;
        logic [7:0] m;
`ifdef ERR_INJECT_EN
        m = mask;
        inj_mask = mask;
`else
        m = 8'd0 & mask;
`endif
        build_model(taps, seed, pre, len, m);
        out_cnt = 0; in_cnt = 0; done_pend = 0; prev_stall = 0;
        stall_used = 0; stall_left = 0; ready_mode = rmode; valid_mode = vmode;
        @(posedge Clk); #1;
        cfg_taps = taps; cfg_seed = seed; cfg_pre_len = pre; cfg_msg_len = len;
        start = 1'b1; mon_en = 1; drv_en = 1;
        @(posedge Clk); #1;
        start = 1'b0;
        s_cyc = cyc;
        check("first_valid", out_valid, 1);
        check("busy_set", busy, 1);
        if (poke_busy) begin
            repeat (3) @(posedge Clk);
            #1;
            cfg_taps = TAPS[$urandom_range(0, 8)]; cfg_seed = 7'($urandom);
            cfg_pre_len = 4'($urandom); cfg_msg_len = 6'($urandom);
            start = 1'b1;
            @(posedge Clk); #1;
            start = 1'b0;
        end
        if (abort_at >= 0) begin
            t = 0;
            while (out_cnt < abort_at && t < 3000) begin @(negedge Clk); t++; end
            check("abort_reached", out_cnt >= abort_at, 1);
            @(posedge Clk); #1;
            mon_en = 0; drv_en = 0; in_valid = 1'b0;
            Reset = 1'b0;
            #1;
            check("abort_out_valid", out_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_in_ready", in_ready, 0);
            repeat (2) @(posedge Clk);
            #1;
            Reset = 1'b1;
            return;
        end
        t = 0;
        while (!done && t < 3000) begin @(negedge Clk); t++; end
        if (t >= 3000) begin
            check("frame_timeout", done, 1);
        end else begin
            check("bytes_out", out_cnt, 64);
            check("bytes_in", in_cnt, exp_len);
            if (rmode == 0 && vmode == 0) check("frame_cycles", cyc - s_cyc, 64);
            start = 1'b1;
            @(posedge Clk); #1;
            start = 1'b0;
            check("start_on_done_busy", busy, 0);
            check("start_on_done_valid", out_valid, 0);
            @(negedge Clk);
            check("done_one_cycle", done, 0);
        end
        mon_en = 0; drv_en = 0; in_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        Reset = 1'b1;

        fill_msg();
        msg[0] = 8'h41;
        run_frame(7'h60, 7'h01, 4'd10, 6'd1, 0, 0, 8'h00, 0, -1);
        check("model_b0", exp_f[0], 8'h21);
        check("model_b1", exp_f[1], 8'h22);
        check("model_b6", exp_f[6], 8'hE1);
        check("model_b10", exp_f[10], 8'h59);
        check("dut_b0", cap[0], 8'h21);
        check("dut_b1", cap[1], 8'h22);
        for (int i = 0; i < 64; i++) prev_cap[i] = cap[i];

        run_frame(7'h60, 7'h00, 4'd10, 6'd1, 0, 0, 8'h00, 0, -1);
        for (int i = 0; i < 64; i++) check($sformatf("seed0_byte%0d", i), cap[i], prev_cap[i]);

        fill_msg();
        run_frame(7'h7E, 7'($urandom), 4'd3, 6'd60, 1, 1, 8'h00, 0, -1);
        check("pre_clamp_first_body", exp_pre, 10);

        fill_msg();
        run_frame(7'h48, 7'h05, 4'd12, 6'd20, 2, 0, 8'h00, 0, -1);

        fill_msg();
        run_frame(7'h5C, 7'h33, 4'd15, 6'd40, 1, 1, 8'h00, 0, 30);
        run_frame(7'h5C, 7'h33, 4'd15, 6'd40, 0, 0, 8'h00, 0, -1);

        fill_msg();
        run_frame(7'h60, 7'h01, 4'd10, 6'd40, 0, 0, 8'h01, 0, -1);

        fill_msg();
        run_frame(7'h7B, 7'h7F, 4'd15, 6'd49, 1, 1, 8'h00, 1, -1);
        run_frame(7'h69, 7'h2A, 4'd11, 6'd0, 1, 0, 8'h00, 0, -1);

        for (int k = 0; k < 6; k++) begin
            fill_msg();
            run_frame(TAPS[$urandom_range(0, 8)], 7'($urandom), 4'($urandom), 6'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 1), 8'($urandom),
                      bit'($urandom_range(0, 1)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
